// File: rtl/gelu_pkg.sv
// Shared constants and types for the GELU result unpacker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: default vector geometry (64 elements x 8 bits), producer
// pipeline latency, the vector slot type and the unpacker state encoding.
package gelu_pkg;

  localparam int GELU_DIM      = 64;
  localparam int GELU_OUT_W    = 8;
  localparam int GELU_PIPE_LAT = 3;

  typedef logic [GELU_DIM*GELU_OUT_W-1:0] gelu_vec_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } unpack_state_t;

endpackage

// File: rtl/gelu_vec_fifo.sv
// Vector-slot FIFO holding whole GELU result vectors until serialized.
// Latency: a written slot is visible on head_data/empty the cycle after the write edge.
// Backpressure: none internally; writer must respect full, reader must respect empty.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset (pointers only)
//   wr_en, wr_data    write one vector into the tail slot
//   rd_en             retire the head slot
//   head_data         slot at the read pointer (combinational)
//   next_data         slot after the head, used for gap-free vector switch-over
//   full, empty       derived from pointers carrying one extra wrap bit
//   has_next          at least two slots occupied
//   free_slots        DEPTH minus occupied slots
module gelu_vec_fifo #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      rd_en,
  output logic [WIDTH-1:0]          head_data,
  output logic [WIDTH-1:0]          next_data,
  output logic                      full,
  output logic                      empty,
  output logic                      has_next,
  output logic [$clog2(DEPTH):0]    free_slots
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      used;
  logic [AW-1:0]    rd_idx_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage carries no reset; validity is tracked purely by the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign used        = wr_ptr - rd_ptr;
  // DEPTH is a power of two, so the index wraps naturally.
  assign rd_idx_next = rd_ptr[AW-1:0] + AW'(1);

  assign head_data  = mem[rd_ptr[AW-1:0]];
  assign next_data  = mem[rd_idx_next];
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign has_next   = (used > (AW+1)'(1));
  assign free_slots = (AW+1)'(DEPTH) - used;

endmodule

// File: rtl/gelu_vec_unpacker.sv
// Captures GELU result vectors, buffers them, and serializes each into WPV words.
// Latency: first word valid 2 cycles after the capture edge; then one word per accepted cycle.
// Backpressure: out_ready stalls the word stream; upstream is throttled via issue_ok (it cannot be stalled).
//
// Ports:
//   clk_p, rst_p       clock (rising edge), asynchronous active-high reset
//   gelu, gelu_valid_n result vector (element 0 in MSBs), active-low one-cycle valid
//   out_data/valid/ready  serialized word stream, registered outputs
//   issue_ok           registered: free slots exceed vectors already in flight
//   in_flight_inc      pulse per vector issued into the GELU pipeline
//   overflow_err       sticky: a vector arrived while the FIFO was full
// Optional (macro GELU_UNPACK_LAST_EN): out_last marks the final word of a
// vector; out_vec_id counts emitted vectors modulo 256.
module gelu_vec_unpacker
  import gelu_pkg::*;
#(
  parameter int DIMENTION    = GELU_DIM,
  parameter int OUTPUT_WIDTH = GELU_OUT_W,
  parameter int WORD_WIDTH   = 64,
  parameter int FIFO_DEPTH   = 4,
  parameter int PIPE_LAT     = GELU_PIPE_LAT
) (
  input  logic                              clk_p,
  input  logic                              rst_p,
  input  logic [DIMENTION*OUTPUT_WIDTH-1:0] gelu,
  input  logic                              gelu_valid_n,
  output logic [WORD_WIDTH-1:0]             out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              issue_ok,
  input  logic                              in_flight_inc,
  output logic                              overflow_err
`ifdef GELU_UNPACK_LAST_EN
  ,
  output logic                              out_last,
  output logic [7:0]                        out_vec_id
`endif
);

  localparam int VEC_W = DIMENTION * OUTPUT_WIDTH;
  localparam int WPV   = VEC_W / WORD_WIDTH;
  localparam int WCW   = (WPV > 1) ? $clog2(WPV) : 1;
  localparam int FSW   = $clog2(FIFO_DEPTH) + 1;
  localparam int IFW   = (PIPE_LAT > 0) ? $clog2(PIPE_LAT + 1) : 1;
  localparam logic [WCW-1:0] LAST_IDX = WCW'(WPV - 1);

  // Word k is the k-th WORD_WIDTH slice counted from the MSB end, so the
  // lowest-index element of the word lands in its MSBs.
  function automatic logic [WORD_WIDTH-1:0] word_of(input logic [VEC_W-1:0] v,
                                                    input logic [WCW-1:0]   k);
    logic [VEC_W-1:0] s;
    s = v << (int'(k) * WORD_WIDTH);
    return s[VEC_W-1 -: WORD_WIDTH];
  endfunction

  unpack_state_t  state;
  logic [WCW-1:0] word_cnt;
  logic [WCW-1:0] load_idx;
  logic           capture;
  logic           fifo_wr;
  logic           fifo_rd;
  logic           fifo_full;
  logic           fifo_empty;
  logic           fifo_has_next;
  logic [VEC_W-1:0] head_vec;
  logic [VEC_W-1:0] next_vec;
  logic [VEC_W-1:0] load_vec;
  logic [FSW-1:0] free_slots;
  logic           last_word;
  logic           accept;
  logic           accept_last;
  logic           load_en;
  logic [IFW-1:0] in_flight;
  logic [IFW-1:0] in_flight_nxt;
  int             free_nxt;

  gelu_vec_fifo #(
    .WIDTH (VEC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk_p),
    .rst        (rst_p),
    .wr_en      (fifo_wr),
    .wr_data    (gelu),
    .rd_en      (fifo_rd),
    .head_data  (head_vec),
    .next_data  (next_vec),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .has_next   (fifo_has_next),
    .free_slots (free_slots)
  );

  // Full is the pre-edge value, so a vector arriving on the same edge that
  // retires the head of a full FIFO is still dropped.
  assign capture     = !gelu_valid_n;
  assign fifo_wr     = capture && !fifo_full;
  assign last_word   = (word_cnt == LAST_IDX);
  assign accept      = (state == STREAM) && out_valid && out_ready;
  assign accept_last = accept && last_word;
  assign fifo_rd     = accept_last;

  // A new word is loaded on entry to STREAM (out_valid still low) or when
  // the current word is taken, unless it was the last word with nothing
  // queued behind it.
  assign load_en  = (state == STREAM) &&
                    (!out_valid || (out_ready && !(last_word && !fifo_has_next)));
  assign load_vec = accept_last ? next_vec : head_vec;

  always_comb begin
    load_idx = word_cnt;
    if (out_valid) load_idx = last_word ? '0 : word_cnt + WCW'(1);
  end

  always_ff @(posedge clk_p or posedge rst_p) begin
    if (rst_p) begin
      state     <= IDLE;
      word_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          out_valid <= 1'b0;
          word_cnt  <= '0;
          if (!fifo_empty) state <= STREAM;
        end
        STREAM: begin
          if (load_en) begin
            out_valid <= 1'b1;
            out_data  <= word_of(load_vec, load_idx);
            word_cnt  <= load_idx;
          end else if (accept_last) begin
            out_valid <= 1'b0;
            word_cnt  <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // In-flight count: issued but not yet arrived. Arrival counts whether the
  // vector was captured or dropped.
  always_comb begin
    in_flight_nxt = in_flight;
    if (in_flight_inc && !capture && (in_flight != IFW'(PIPE_LAT)))
      in_flight_nxt = in_flight + IFW'(1);
    else if (!in_flight_inc && capture && (in_flight != '0))
      in_flight_nxt = in_flight - IFW'(1);
    free_nxt = int'(free_slots) - (fifo_wr ? 1 : 0) + (fifo_rd ? 1 : 0);
  end

  // issue_ok is computed from post-edge occupancy so it never lags a drain.
  always_ff @(posedge clk_p or posedge rst_p) begin
    if (rst_p) begin
      in_flight    <= '0;
      issue_ok     <= 1'b1;
      overflow_err <= 1'b0;
    end else begin
      in_flight <= in_flight_nxt;
      issue_ok  <= (free_nxt > int'(in_flight_nxt));
      if (capture && fifo_full) overflow_err <= 1'b1;
    end
  end

`ifdef GELU_UNPACK_LAST_EN
  always_ff @(posedge clk_p or posedge rst_p) begin
    if (rst_p) begin
      out_last   <= 1'b0;
      out_vec_id <= '0;
    end else begin
      if (load_en)          out_last <= (load_idx == LAST_IDX);
      else if (accept_last) out_last <= 1'b0;
      if (accept_last) out_vec_id <= out_vec_id + 8'd1;
    end
  end
`endif

endmodule
